// File: rtl/alu_decoder_block_pkg.sv
// rtl/alu_decoder_block_pkg.sv - shared address and action constants for the ALU decoder
package alu_decoder_block_pkg;

  localparam logic [1:0] ROM_PREFIX = 2'b10;
  localparam logic [4:0] ALU_B_ADDR = 5'b11000;

  localparam logic [3:0] ACT_NONE = 4'h0;
  localparam logic [3:0] ACT_CPL  = 4'h1;
  localparam logic [3:0] ACT_CLL  = 4'h2;
  // WPA is reserved: named here so nobody reuses the code, deliberately never decoded.
  localparam logic [3:0] ACT_WPA  = 4'h6;
  localparam logic [3:0] ACT_SRU  = 4'h7;

  function automatic logic in_rom_window(input logic [4:0] addr);
    return addr[4:3] == ROM_PREFIX;
  endfunction

endpackage

// File: rtl/alu_decoder_block_if.sv
// rtl/alu_decoder_block_if.sv - bus/strobe/action bundle between the sequencer and the ALU decoder
interface alu_decoder_block_if;
  import alu_decoder_block_pkg::*;

  logic       t34;
  logic [4:0] raddr;
  logic [4:0] waddr;
  logic [3:0] action;
  logic       nromoe;
  logic       nread_alu_b;
  logic       nwrite_alu_b;
  logic       naction_cpl;
  logic       naction_cll;
  logic       naction_sru;
  logic [3:0] last_action;

  modport master (
    output t34, raddr, waddr, action,
    input  nromoe, nread_alu_b, nwrite_alu_b,
    input  naction_cpl, naction_cll, naction_sru, last_action
  );

  modport slave (
    input  t34, raddr, waddr, action,
    output nromoe, nread_alu_b, nwrite_alu_b,
    output naction_cpl, naction_cll, naction_sru, last_action
  );

endinterface

// File: rtl/alu_action_dec.sv
// rtl/alu_action_dec.sv - one-hot active-low decode of the microcode action field
module alu_action_dec
  import alu_decoder_block_pkg::*;
(
  input  logic [3:0] action,
  output logic       naction_cpl,
  output logic       naction_cll,
  output logic       naction_sru
);

  always_comb begin
    naction_cpl = 1'b1;
    naction_cll = 1'b1;
    naction_sru = 1'b1;
    case (action)
      ACT_CPL: naction_cpl = 1'b0;
      ACT_CLL: naction_cll = 1'b0;
      ACT_SRU: naction_sru = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_decoder_block.sv
// rtl/alu_decoder_block.sv - ROM/ALU-B address decode, action decode and last-action capture
module alu_decoder_block
  import alu_decoder_block_pkg::*;
(
  input logic               clk,
  input logic               nreset,
  alu_decoder_block_if.slave bus
);

  logic       t34_active;
  logic [3:0] last_action_q;

  // Address strobes only fire during T3/T4; the action decode is ungated.
  assign t34_active       = ~bus.t34;
  assign bus.nromoe       = ~(t34_active && in_rom_window(bus.raddr));
  assign bus.nread_alu_b  = ~(t34_active && (bus.raddr == ALU_B_ADDR));
  assign bus.nwrite_alu_b = ~(t34_active && (bus.waddr == ALU_B_ADDR));

  alu_action_dec u_action_dec (
    .action      (bus.action),
    .naction_cpl (bus.naction_cpl),
    .naction_cll (bus.naction_cll),
    .naction_sru (bus.naction_sru)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      last_action_q <= ACT_NONE;
    end else if (bus.action != ACT_NONE) begin
      last_action_q <= bus.action;
    end
  end

  assign bus.last_action = last_action_q;

endmodule

// File: tb/tb_alu_decoder_block.sv
// tb/tb_alu_decoder_block.sv - table-driven decode vectors plus capture/reset sequences
module tb_alu_decoder_block;

  typedef struct {
    logic [4:0] raddr;
    logic [4:0] waddr;
    logic       t34;
    logic [3:0] action;
    logic       exp_nromoe;
    logic       exp_nrd;
    logic       exp_nwr;
    logic       exp_cpl;
    logic       exp_cll;
    logic       exp_sru;
  } vec_t;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  vec_t vecs[$];

  alu_decoder_block_if bus ();

  alu_decoder_block dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [4:0] got, input logic [4:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] r, input logic [4:0] w, input logic t, input logic [3:0] a);
    bus.raddr  = r;
    bus.waddr  = w;
    bus.t34    = t;
    bus.action = a;
  endtask

  task automatic check_decode(input string tag, input int idx, input vec_t v);
    check({tag, " nromoe"},       idx, {4'b0, bus.nromoe},       {4'b0, v.exp_nromoe});
    check({tag, " nread_alu_b"},  idx, {4'b0, bus.nread_alu_b},  {4'b0, v.exp_nrd});
    check({tag, " nwrite_alu_b"}, idx, {4'b0, bus.nwrite_alu_b}, {4'b0, v.exp_nwr});
    check({tag, " naction_cpl"},  idx, {4'b0, bus.naction_cpl},  {4'b0, v.exp_cpl});
    check({tag, " naction_cll"},  idx, {4'b0, bus.naction_cll},  {4'b0, v.exp_cll});
    check({tag, " naction_sru"},  idx, {4'b0, bus.naction_sru},  {4'b0, v.exp_sru});
  endtask

  initial begin
    vec_t v;
    vec_t hold;
    int   lows;

    for (int t = 0; t < 2; t++) begin
      for (int r = 0; r < 32; r++) begin
        v = '{raddr: 5'(r), waddr: 5'd0, t34: 1'(t), action: 4'd0,
              exp_nromoe: !(t == 0 && r >= 16 && r <= 23), exp_nrd: !(t == 0 && r == 24),
              exp_nwr: 1'b1, exp_cpl: 1'b1, exp_cll: 1'b1, exp_sru: 1'b1};
        vecs.push_back(v);
      end
      for (int w = 0; w < 32; w++) begin
        v = '{raddr: 5'd0, waddr: 5'(w), t34: 1'(t), action: 4'd0,
              exp_nromoe: 1'b1, exp_nrd: 1'b1, exp_nwr: !(t == 0 && w == 24),
              exp_cpl: 1'b1, exp_cll: 1'b1, exp_sru: 1'b1};
        vecs.push_back(v);
      end
    end
    for (int a = 0; a < 16; a++) begin
      v = '{raddr: 5'd0, waddr: 5'd0, t34: 1'b1, action: 4'(a),
            exp_nromoe: 1'b1, exp_nrd: 1'b1, exp_nwr: 1'b1,
            exp_cpl: !(a == 1), exp_cll: !(a == 2), exp_sru: !(a == 7)};
      vecs.push_back(v);
    end
    v = '{raddr: 5'd24, waddr: 5'd24, t34: 1'b0, action: 4'd0,
          exp_nromoe: 1'b1, exp_nrd: 1'b0, exp_nwr: 1'b0,
          exp_cpl: 1'b1, exp_cll: 1'b1, exp_sru: 1'b1};
    vecs.push_back(v);

    // Reset state, with a live decode while reset is held.
    drive(5'd16, 5'd24, 1'b0, 4'd2);
    #3;
    check("reset last_action", 0, {1'b0, bus.last_action}, 5'd0);
    hold = '{raddr: 5'd16, waddr: 5'd24, t34: 1'b0, action: 4'd2,
             exp_nromoe: 1'b0, exp_nrd: 1'b1, exp_nwr: 1'b0,
             exp_cpl: 1'b1, exp_cll: 1'b0, exp_sru: 1'b1};
    check_decode("in reset", 0, hold);
    @(posedge clk);
    #1;
    check("reset across edge", 0, {1'b0, bus.last_action}, 5'd0);
    @(negedge clk);
    nreset = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].raddr, vecs[i].waddr, vecs[i].t34, vecs[i].action);
      #1;
      check_decode("vec", i, vecs[i]);
      if (i >= 128 && i < 144) begin
        lows = 0;
        if (!bus.naction_cpl) lows++;
        if (!bus.naction_cll) lows++;
        if (!bus.naction_sru) lows++;
        check("one-hot action", i, 5'(lows > 1), 5'd0);
      end
    end

    // Capture sequence 7, 0, 0.
    @(negedge clk);
    drive(5'd0, 5'd0, 1'b1, 4'd7);
    @(posedge clk);
    #1;
    check("capture 7", 0, {1'b0, bus.last_action}, 5'd7);
    @(negedge clk);
    bus.action = 4'd0;
    @(posedge clk);
    #1;
    check("hold 7 (1)", 1, {1'b0, bus.last_action}, 5'd7);
    @(posedge clk);
    #1;
    check("hold 7 (2)", 2, {1'b0, bus.last_action}, 5'd7);

    // Mid-cycle reset with last_action=7 and active decodes.
    @(negedge clk);
    drive(5'd24, 5'd24, 1'b0, 4'd7);
    hold = '{raddr: 5'd24, waddr: 5'd24, t34: 1'b0, action: 4'd7,
             exp_nromoe: 1'b1, exp_nrd: 1'b0, exp_nwr: 1'b0,
             exp_cpl: 1'b1, exp_cll: 1'b1, exp_sru: 1'b0};
    #1;
    check_decode("pre-reset", 0, hold);
    #1;
    nreset = 1'b0;
    #1;
    check("async clear", 0, {1'b0, bus.last_action}, 5'd0);
    check_decode("during reset", 0, hold);
    @(posedge clk);
    #1;
    check("held in reset", 0, {1'b0, bus.last_action}, 5'd0);
    @(negedge clk);
    #2;
    nreset = 1'b1;
    bus.action = 4'd1;
    #1;
    check("no capture before edge", 0, {1'b0, bus.last_action}, 5'd0);
    @(posedge clk);
    #1;
    check("resume capture", 0, {1'b0, bus.last_action}, 5'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_decoder_block.md
ALU_DECODER_BLOCK -- requirements
Module: alu_decoder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all registered state SHALL clear asynchronously when nreset is low.
REQ-002 The port clk SHALL be a 1-bit input: the system clock, which drives only the registered status logic.
REQ-003 The port nreset SHALL be a 1-bit input: asynchronous reset, active low.
REQ-004 The port t34 SHALL be a 1-bit input: processor T3/T4 strobe, active low (0 means the strobe is active).
REQ-005 The port raddr SHALL be a 5-bit input: the bus read address (register/unit select).
REQ-006 The port waddr SHALL be a 5-bit input: the bus write address.
REQ-007 The port action SHALL be a 4-bit input: the microcode action field.
REQ-008 The port nromoe SHALL be a 1-bit output: ALU ROM output enable, active low.
REQ-009 The port nread_alu_b SHALL be a 1-bit output: read ALU B register, active low.
REQ-010 The port nwrite_alu_b SHALL be a 1-bit output: write ALU B register, active low.
REQ-011 The port naction_cpl SHALL be a 1-bit output: complement-L action, active low.
REQ-012 The port naction_cll SHALL be a 1-bit output: clear-L action, active low.
REQ-013 The port naction_sru SHALL be a 1-bit output: start-rotate/shift-unit action, active low.
REQ-014 The port last_action SHALL be a 4-bit output: registered copy of the most recent non-zero action code.

Function
REQ-015 nromoe SHALL be 0 iff raddr[4:3]=2'b10 and t34=0; it SHALL be 1 for every other raddr value or when t34=1.
REQ-016 nread_alu_b SHALL be 0 iff raddr=5'b11000 and t34=0; otherwise it SHALL be 1.
REQ-017 raddr=5'b11000 SHALL NOT assert nromoe, because the ROM window is raddr 10xxx only.
REQ-018 nwrite_alu_b SHALL be 0 iff waddr=5'b11000 and t34=0; otherwise it SHALL be 1.
REQ-019 The action outputs SHALL NOT be gated by t34.
- naction_cpl=0 iff action=4'b0001.
- naction_cll=0 iff action=4'b0010.
- naction_sru=0 iff action=4'b0111.
- Every other action code, including 0000 and 0110, SHALL leave all three outputs at 1.
REQ-020 At most one action output SHALL be low at any time.
REQ-021 All decode outputs (REQ-015 to REQ-019) SHALL be purely combinational functions of their inputs.
- They SHALL be independent of clk and nreset.
- They SHALL settle within 30 ns of any input change.
REQ-022 The read decode and the write decode SHALL be independent; simultaneous raddr=waddr=11000 with t34=0 SHALL assert both nread_alu_b and nwrite_alu_b.
REQ-023 On each rising edge of clk, if action≠0, last_action SHALL load action; if action=0, last_action SHALL hold its value.

Reset
REQ-024 While nreset=0, last_action SHALL be 4'b0000, asynchronously and regardless of clk.
REQ-025 Reset SHALL NOT affect the combinational decode outputs.
REQ-026 Deasserting nreset in the middle of an operation SHALL resume capture at the next rising edge of clk.

Structure
REQ-027 A shared package SHALL hold the constants listed below.
- ROM window prefix 2'b10.
- ALU B address 5'b11000.
- Action codes: CPL=4'h1, CLL=4'h2, WPA=4'h6 (reserved, not decoded), SRU=4'h7.
REQ-028 A single sub-module, alu_action_dec, SHALL implement the one-hot, active-low action decode; the address decode and the last_action register SHALL remain in the top level.

Verification
REQ-029 The bench SHALL sweep raddr 0–31 with t34 at 0 and 1.
- nromoe=0 only for raddr 16–23 with t34=0.
- nread_alu_b=0 only for raddr=24 with t34=0.
REQ-030 The bench SHALL sweep waddr 0–31 with t34 at 0 and 1; nwrite_alu_b=0 only for waddr=24 with t34=0.
REQ-031 The bench SHALL sweep action 0–15 with t34=1.
- action=1 gives cpl=0; action=2 gives cll=0; action=7 gives sru=0.
- action=6 and all other codes give all three action outputs at 1.
REQ-032 The bench SHALL apply raddr=24, waddr=24, t34=0 together and require nread_alu_b=0 and nwrite_alu_b=0.
REQ-033 The bench SHALL apply action sequence 7, 0, 0 over clk edges and require last_action=7, held at 7.
REQ-034 The bench SHALL assert nreset mid-run with last_action=7 and require last_action=0 immediately, with the decode outputs unchanged.
